// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4:1 mux scan sampler.
// Used by mux_scan_sampler (optional feature macro: SCAN_AUTO_RESTART_EN).
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Settle timer: counts up while enabled and pulses o_tc on the last settle cycle,
// wrapping to zero on that same edge so the next channel starts from a clean count.
module mux_scan_settle_cnt #(
    parameter int unsigned TERM = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(TERM + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(TERM - 1);

    logic [CW-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps a 4:1 mux select through all channels, samples y_in after SETTLE cycles each,
// and presents the 4-bit word with valid/ready. SCAN_AUTO_RESTART_EN: rescan after each handshake.
//
// state | meaning
// IDLE  | select parked at 00, waiting for start
// SCAN  | select driving channel r_ch, settle timer running
// HOLD  | word complete, valid held until ready
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              y_in,
    output logic              s1,
    output logic              s0,
    output logic              busy,
    output logic [NUM_CH-1:0] data,
    output logic              valid,
    input  logic              ready
);

    scan_state_t       r_state;
    logic [SEL_W-1:0]  r_ch;
    logic              r_busy;
    logic              r_valid;
    logic [NUM_CH-1:0] r_data;
    logic              w_scan;
    logic              w_tc;
    logic              w_restart;

    assign w_scan = (r_state == SCAN);

`ifdef SCAN_AUTO_RESTART_EN
    assign w_restart = 1'b1;
`else
    assign w_restart = start;
`endif

    mux_scan_settle_cnt #(
        .TERM (SETTLE)
    ) u_settle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (!w_scan),
        .i_en  (w_scan),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ch <= '0;
                    if (start) begin
                        r_state <= SCAN;
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_tc) begin
                        r_data[r_ch] <= y_in;
                        if (r_ch == SEL_W'(NUM_CH - 1)) begin
                            r_state <= HOLD;
                            r_ch    <= '0;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // a handshake edge can also launch the next scan (back-to-back)
                    if (r_valid && ready) begin
                        r_valid <= 1'b0;
                        if (w_restart) begin
                            r_state <= SCAN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ch    <= '0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s1    = r_ch[1];
    assign s0    = r_ch[0];
    assign busy  = r_busy;
    assign valid = r_valid;
    assign data  = r_data;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: three instances (SETTLE=1,2,3) each driving a modelled 4:1 mux,
// checked every cycle against a timing model plus hand-computed literals.
module tb_mux_scan_sampler;

    localparam int N = 3;
`ifdef SCAN_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] start = '0;
    logic [N-1:0] ready = '0;
    logic [N-1:0] y_in;
    logic [N-1:0] s1, s0, busy, valid;
    logic [3:0]   data [N];
    logic [3:0]   d_pat [N];
    logic         ovr = 1'b0;
    logic [N-1:0] rnd = '0;

    int checks = 0;
    int failures = 0;

    int         m_t     [N];
    bit         m_scan  [N];
    bit         m_valid [N];
    logic [3:0] m_data  [N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            assign y_in[g] = ovr ? rnd[g] : d_pat[g][{s1[g], s0[g]}];
            mux_scan_sampler #(.SETTLE(g + 1)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .start (start[g]),
                .y_in  (y_in[g]),
                .s1    (s1[g]),
                .s0    (s0[g]),
                .busy  (busy[g]),
                .data  (data[g]),
                .valid (valid[g]),
                .ready (ready[g])
            );
        end
    endgenerate

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: a scan started at edge E has the select on channel t/SETTLE for t cycles after E,
    // bit k equals mux input d[k], and the word appears 4*SETTLE cycles after E.
    initial begin
        for (int g = 0; g < N; g++) begin
            m_t[g] = 0; m_scan[g] = 0; m_valid[g] = 0; m_data[g] = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int g = 0; g < N; g++) begin
                if (!rst_n) begin
                    m_t[g] = 0; m_scan[g] = 0; m_valid[g] = 0; m_data[g] = '0;
                end else if (m_scan[g]) begin
                    m_t[g]++;
                    if (m_t[g] % (g + 1) == 0)
                        m_data[g][m_t[g] / (g + 1) - 1] = d_pat[g][m_t[g] / (g + 1) - 1];
                    if (m_t[g] == 4 * (g + 1)) begin
                        m_scan[g] = 0;
                        m_valid[g] = 1;
                    end
                end else if (m_valid[g]) begin
                    if (ready[g]) begin
                        m_valid[g] = 0;
                        if (start[g] || AUTO) begin
                            m_scan[g] = 1;
                            m_t[g] = 0;
                        end
                    end
                end else if (start[g]) begin
                    m_scan[g] = 1;
                    m_t[g] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int g = 0; g < N; g++) begin
                    check($sformatf("u%0d_sel", g), int'({s1[g], s0[g]}),
                          m_scan[g] ? m_t[g] / (g + 1) : 0);
                    check($sformatf("u%0d_busy", g), int'(busy[g]), int'(m_scan[g]));
                    check($sformatf("u%0d_valid", g), int'(valid[g]), int'(m_valid[g]));
                    check($sformatf("u%0d_data", g), int'(data[g]), int'(m_data[g]));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < N; g++) begin
            check($sformatf("%s_u%0d_sel", tag, g), int'({s1[g], s0[g]}), 0);
            check($sformatf("%s_u%0d_busy", tag, g), int'(busy[g]), 0);
            check($sformatf("%s_u%0d_valid", tag, g), int'(valid[g]), 0);
            check($sformatf("%s_u%0d_data", tag, g), int'(data[g]), 0);
        end
    endtask

    initial begin
        d_pat[0] = 4'b1101;
        d_pat[1] = 4'b1010;
        d_pat[2] = 4'b0110;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // scan on all units; start also pulsed at E0+1 and E0+2 while busy
        start = '1;
        @(negedge clk);
        check("s1_sel_e0", int'({s1[0], s0[0]}), 0);
        check("s1_busy_e0", int'(busy[0]), 1);
        @(negedge clk);
        check("s1_sel_e1", int'({s1[0], s0[0]}), 1);
        @(negedge clk);
        check("s1_sel_e2", int'({s1[0], s0[0]}), 2);
        start = '0;
        @(negedge clk);
        check("s1_sel_e3", int'({s1[0], s0[0]}), 3);
        check("s1_valid_e3", int'(valid[0]), 0);
        @(negedge clk);
        check("s1_valid_e4", int'(valid[0]), 1);
        check("s1_data", int'(data[0]), 4'b1101);
        check("model_s1_data", int'(m_data[0]), 4'b1101);
        repeat (7) @(negedge clk);
        check("s3_valid_e11", int'(valid[2]), 0);
        check("s3_busy_e11", int'(busy[2]), 1);
        @(negedge clk);
        check("s3_valid_e12", int'(valid[2]), 1);
        check("s3_data", int'(data[2]), 4'b0110);
        check("model_s3_data", int'(m_data[2]), 4'b0110);
        check("s2_data", int'(data[1]), 4'b1010);

        // backpressure with y_in scrambled
        ovr = 1'b1;
        repeat (5) begin
            rnd = N'($urandom);
            @(negedge clk);
            check("bp_valid", int'(valid), 7);
            check("bp_s3_data", int'(data[2]), 4'b0110);
        end
        ovr = 1'b0;
        ready = '1;
        @(negedge clk);
        check("bp_release_valid", int'(valid), 0);
        ready = '0;

`ifndef SCAN_AUTO_RESTART_EN
        // ready while idle has no effect
        ready = '1;
        repeat (3) @(negedge clk);
        check("idle_ready_busy", int'(busy), 0);
        check("idle_ready_valid", int'(valid), 0);
        ready = '0;

        // back-to-back: handshake and start in the same cycle on the SETTLE=2 unit
        start = 3'b010;
        @(negedge clk);
        start = '0;
        repeat (8) @(negedge clk);
        check("b2b_first_valid", int'(valid[1]), 1);
        repeat (2) @(negedge clk);
        check("b2b_hold_valid", int'(valid[1]), 1);
        d_pat[1] = 4'b0101;
        ready = 3'b010;
        start = 3'b010;
        @(negedge clk);
        check("b2b_hs_valid", int'(valid[1]), 0);
        check("b2b_hs_busy", int'(busy[1]), 1);
        ready = '0;
        start = '0;
        repeat (7) @(negedge clk);
        check("b2b_early_valid", int'(valid[1]), 0);
        @(negedge clk);
        check("b2b_second_valid", int'(valid[1]), 1);
        check("b2b_second_data", int'(data[1]), 4'b0101);
        ready = '1;
        @(negedge clk);
        ready = '0;
`endif

        // reset during cycle 3 of a scan
        start = '1;
        @(negedge clk);
        start = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midscan_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d_pat[1] = 4'b1010;
        start = '1;
        @(negedge clk);
        start = '0;
        repeat (12) @(negedge clk);
        check("recover_valid", int'(valid), 7);
        check("recover_s3_data", int'(data[2]), 4'b0110);

`ifdef SCAN_AUTO_RESTART_EN
        // ready held high: one word every 4*SETTLE+1 cycles with no start
        ready = '1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!valid[1] && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("auto_first_valid", int'(valid[1]), 1);
        end
        repeat (8) @(negedge clk);
        check("auto_gap_valid", int'(valid[1]), 0);
        @(negedge clk);
        check("auto_period_valid", int'(valid[1]), 1);
        ready = '0;
`else
        ready = '1;
        @(negedge clk);
        ready = '0;
        repeat (2) @(negedge clk);
        check("final_idle_busy", int'(busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
